// File: rtl/spi_host_writer.sv
// SPI mode-0 host: serialises a valid/ready byte stream MSB first, one CS-low window per tx_last-framed transaction.
// Define SPI_HOST_READBACK_EN to capture spi_miso into rx_data_o/rx_valid_o; otherwise those outputs are tied low.
module spi_host_writer #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  output logic       spi_cs_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    NEXT,
    HOLD,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic [7:0]       txShift_q, txShift_d;
  logic             last_q, last_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             handshake;
  logic             byteDone;

  assign tx_ready_o = !reset_i && ((state_q == IDLE) || (state_q == NEXT));
  assign handshake  = tx_valid_i && tx_ready_o;

  // Next-state logic; every counter is reloaded when its state is entered and counts down to zero.
  always_comb begin
    state_d   = state_q;
    divCnt_d  = divCnt_q;
    bitCnt_d  = bitCnt_q;
    gapCnt_d  = gapCnt_q;
    txShift_d = txShift_q;
    last_d    = last_q;
    mosi_d    = mosi_q;
    byteDone  = 1'b0;

    case (state_q)
      IDLE, NEXT: begin
        if (handshake) begin
          state_d   = LOW;
          divCnt_d  = DIV_LOAD;
          bitCnt_d  = 3'd7;
          txShift_d = tx_data_i;
          last_d    = tx_last_i;
          mosi_d    = tx_data_i[7];
        end
      end
      LOW: begin
        if (divCnt_q == '0) begin
          state_d  = HIGH;
          divCnt_d = DIV_LOAD;
        end else begin
          divCnt_d = divCnt_q - DIV_ONE;
        end
      end
      HIGH: begin
        if (divCnt_q != '0) begin
          divCnt_d = divCnt_q - DIV_ONE;
        end else if (bitCnt_q != 3'd0) begin
          state_d   = LOW;
          divCnt_d  = DIV_LOAD;
          bitCnt_d  = bitCnt_q - 3'd1;
          txShift_d = {txShift_q[6:0], 1'b0};
          mosi_d    = txShift_q[6];
        end else begin
          byteDone = 1'b1;
          if (last_q) begin
            state_d  = HOLD;
            divCnt_d = DIV_LOAD;
          end else begin
            state_d = NEXT;
          end
        end
      end
      HOLD: begin
        if (divCnt_q == '0) begin
          state_d  = GAP;
          gapCnt_d = GAP_LOAD;
          mosi_d   = 1'b0;
        end else begin
          divCnt_d = divCnt_q - DIV_ONE;
        end
      end
      GAP: begin
        if (gapCnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q - GAP_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sclk_d = (state_d == HIGH);
    cs_d   = (state_d == IDLE) || (state_d == GAP);
    busy_d = (state_d != IDLE);
  end

  // SPI pins are registered from the next state so they never glitch on state decode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      divCnt_q  <= '0;
      bitCnt_q  <= 3'd0;
      gapCnt_q  <= '0;
      txShift_q <= 8'h00;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      divCnt_q  <= divCnt_d;
      bitCnt_q  <= bitCnt_d;
      gapCnt_q  <= gapCnt_d;
      txShift_q <= txShift_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_cs_o   = cs_q;
  assign spi_mosi_o = mosi_q;
  assign busy_o     = busy_q;

`ifdef SPI_HOST_READBACK_EN
  logic [7:0] rxShift_q, rxShift_d;
  logic [7:0] rxData_q;
  logic       rxValid_q;
  logic       firstHigh;

  // MISO is taken once per bit, in the first HIGH cycle; with CLK_DIV=1 that is also the byte's last cycle.
  assign firstHigh = (state_q == HIGH) && (divCnt_q == DIV_LOAD);

  always_comb begin
    rxShift_d = rxShift_q;
    if (firstHigh) begin
      rxShift_d = {rxShift_q[6:0], spi_miso_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rxShift_q <= 8'h00;
      rxData_q  <= 8'h00;
      rxValid_q <= 1'b0;
    end else begin
      rxShift_q <= rxShift_d;
      rxValid_q <= byteDone;
      if (byteDone) begin
        rxData_q <= rxShift_d;
      end
    end
  end

  assign rx_data_o  = rxData_q;
  assign rx_valid_o = rxValid_q;
`else
  logic unusedReadback;

  assign unusedReadback = spi_miso_i ^ byteDone;
  assign rx_data_o      = 8'h00;
  assign rx_valid_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_host_writer.sv
// Self-checking bench for spi_host_writer: a protocol-level model predicts MOSI bits, frame lengths and RX bytes.
// Honours SPI_HOST_READBACK_EN the same way the design does.
`timescale 1ns/1ps
module tb_spi_host_writer;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 2;
`ifdef SPI_HOST_READBACK_EN
  localparam int RX_PER_BYTE = 1;
`else
  localparam int RX_PER_BYTE = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
  logic       txLast = 1'b0;
  logic       txReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       busy;
  logic       spiSclk;
  logic       spiMosi;
  logic       spiMiso;
  logic       spiCs;
  logic       misoLoop = 1'b1;

  assign spiMiso = misoLoop ? spiMosi : 1'b1;

  spi_host_writer #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .tx_data_i (txData),
    .tx_valid_i(txValid),
    .tx_last_i (txLast),
    .tx_ready_o(txReady),
    .rx_data_o (rxData),
    .rx_valid_o(rxValid),
    .busy_o    (busy),
    .spi_sclk_o(spiSclk),
    .spi_mosi_o(spiMosi),
    .spi_miso_i(spiMiso),
    .spi_cs_o  (spiCs)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  // Expected traffic: bits in wire order, RX bytes in completion order, CS-low length per frame.
  bit         bitQ[$];
  logic [7:0] rxQ[$];
  int         frameLenQ[$];
  int         frameAcc = 0;
  bit         inFrame = 1'b0;

  // Observations the scenarios pin with literal values.
  int         lastCsLow = 0;
  int         lastGapLen = 0;
  int         pulseTotal = 0;
  int         rxCount = 0;
  logic [7:0] capture = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic reportFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  task automatic abortRun(input string name);
    reportFail(name);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  endtask

  task automatic resetStats();
    pulseTotal = 0;
    rxCount = 0;
  endtask

  // Presents one byte and returns just after the edge on which it was accepted.
  task automatic sendByte(input logic [7:0] b, input logic last);
    int guard = 0;
    txData = b;
    txLast = last;
    txValid = 1'b1;
    while (!txReady && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!txReady) abortRun("handshakeTimeout");
    @(posedge clk);
    #1;
    for (int i = 7; i >= 0; i--) bitQ.push_back(b[i]);
    rxQ.push_back(misoLoop ? b : 8'hFF);
  endtask

  // idleBefore>0 withholds the byte for that many cycles after the block first offers tx_ready.
  task automatic applyStimulus(input logic [7:0] b, input logic last, input int idleBefore);
    int guard = 0;
    if (idleBefore > 0) begin
      txValid = 1'b0;
      while (!txReady && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (!txReady) abortRun("readyTimeout");
      repeat (idleBefore) begin
        @(negedge clk);
        checkOutput("stallCs", spiCs, 0);
        checkOutput("stallSclk", spiSclk, 0);
        checkOutput("stallReady", txReady, 1);
      end
    end
    // A byte costs 16*CLK_DIV; each boundary adds one NEXT cycle plus any stall; the frame ends with CLK_DIV of hold.
    if (!inFrame) frameAcc = 16 * CLK_DIV;
    else frameAcc = frameAcc + 16 * CLK_DIV + 1 + idleBefore;
    sendByte(b, last);
    if (last) begin
      frameLenQ.push_back(frameAcc + CLK_DIV);
      inFrame = 1'b0;
    end else begin
      inFrame = 1'b1;
    end
  endtask

  task automatic waitIdle();
    int guard = 0;
    txValid = 1'b0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while ((busy || !spiCs) && guard < 5000);
    if (busy || !spiCs) abortRun("idleTimeout");
  endtask

  // Bus monitor: compares every non-reset cycle against the protocol model.
  bit   prevCs = 1'b1;
  bit   prevSclk = 1'b0;
  int   highRun = 1000;
  int   csLowRun = 0;
  int   sclkHighRun = 0;
  int   pulsesInByte = 0;
  bit   haveBit = 1'b0;
  logic expBit = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      highRun = 1000;
      csLowRun = 0;
      sclkHighRun = 0;
      pulsesInByte = 0;
    end else begin
      if (!spiCs) begin
        if (prevCs) begin
          lastGapLen = highRun + 1;
          csLowRun = 1;
        end else begin
          csLowRun++;
        end
        checkOutput("busyWhileSelected", busy, 1);
      end else begin
        if (!prevCs) begin
          highRun = 0;
          lastCsLow = csLowRun;
          if (frameLenQ.size() == 0) reportFail("unexpectedFrameEnd");
          else checkOutput("csLowCycles", csLowRun, frameLenQ.pop_front());
        end else begin
          highRun++;
        end
        if (highRun < CS_GAP) begin
          checkOutput("busyInGap", busy, 1);
          checkOutput("readyInGap", txReady, 0);
        end else begin
          checkOutput("busyIdle", busy, 0);
          checkOutput("readyIdle", txReady, 1);
        end
        checkOutput("mosiDeselected", spiMosi, 0);
        checkOutput("sclkDeselected", spiSclk, 0);
      end

      if (spiSclk) begin
        checkOutput("csDuringSclk", spiCs, 0);
        if (!prevSclk) begin
          sclkHighRun = 1;
          pulseTotal++;
          pulsesInByte++;
          capture = {capture[6:0], spiMosi};
          if (bitQ.size() == 0) begin
            haveBit = 1'b0;
            reportFail("unexpectedSclk");
          end else begin
            haveBit = 1'b1;
            expBit = bitQ.pop_front();
            checkOutput("mosiBit", spiMosi, expBit);
          end
        end else begin
          sclkHighRun++;
          if (haveBit) checkOutput("mosiStableHigh", spiMosi, expBit);
        end
      end else if (prevSclk) begin
        checkOutput("sclkHighCycles", sclkHighRun, CLK_DIV);
      end

      if (rxValid) rxCount++;
      if (!spiSclk && prevSclk && pulsesInByte == 8) begin
        pulsesInByte = 0;
`ifdef SPI_HOST_READBACK_EN
        checkOutput("rxValidAtByteEnd", rxValid, 1);
        if (rxQ.size() == 0) reportFail("unexpectedRxByte");
        else checkOutput("rxData", rxData, rxQ.pop_front());
`else
        checkOutput("rxValidAtByteEnd", rxValid, 0);
`endif
      end else begin
        checkOutput("rxValidQuiet", rxValid, 0);
      end
`ifndef SPI_HOST_READBACK_EN
      checkOutput("rxDataTied", rxData, 0);
`endif
    end
    prevCs = spiCs;
    prevSclk = spiSclk;
  end

  initial begin
    #1_000_000;
    abortRun("watchdog");
  end

  initial begin
    $display("[TB] start CLK_DIV=%0d CS_GAP=%0d readback=%0d", CLK_DIV, CS_GAP, RX_PER_BYTE);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetCs", spiCs, 1);
    checkOutput("resetSclk", spiSclk, 0);
    checkOutput("resetMosi", spiMosi, 0);
    checkOutput("resetReady", txReady, 0);
    checkOutput("resetRxValid", rxValid, 0);
    checkOutput("resetRxData", rxData, 0);
    checkOutput("resetBusy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", txReady, 1);

    $display("[TB] single byte 0xA5, MISO looped back");
    resetStats();
    misoLoop = 1'b1;
    applyStimulus(8'hA5, 1'b1, 0);
    waitIdle();
    checkOutput("s1CsLow", lastCsLow, 34);
    checkOutput("s1MosiBits", capture, 8'hA5);
    checkOutput("s1Pulses", pulseTotal, 8);
    checkOutput("s1RxCount", rxCount, RX_PER_BYTE);

    $display("[TB] three-byte frame with tx_valid held");
    resetStats();
    applyStimulus(8'h80, 1'b0, 0);
    applyStimulus(8'h12, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    waitIdle();
    checkOutput("s2CsLow", lastCsLow, 100);
    checkOutput("s2Pulses", pulseTotal, 24);
    checkOutput("s2RxCount", rxCount, 3 * RX_PER_BYTE);

    $display("[TB] two-byte frame with a 10-cycle source stall");
    resetStats();
    applyStimulus(8'h3C, 1'b0, 0);
    applyStimulus(8'hC3, 1'b1, 10);
    waitIdle();
    checkOutput("s3CsLow", lastCsLow, 77);
    checkOutput("s3MosiBits", capture, 8'hC3);
    checkOutput("s3Pulses", pulseTotal, 16);

    // The gap phase is CS_GAP cycles; the IDLE cycle that accepts the next byte keeps CS high one more.
    $display("[TB] back-to-back single-byte frames");
    resetStats();
    applyStimulus(8'h96, 1'b1, 0);
    applyStimulus(8'h69, 1'b1, 0);
    waitIdle();
    checkOutput("s4GapLen", lastGapLen, CS_GAP + 1);
    checkOutput("s4CsLow", lastCsLow, 34);
    checkOutput("s4MosiBits", capture, 8'h69);
    checkOutput("s4RxCount", rxCount, 2 * RX_PER_BYTE);

    $display("[TB] reset during bit 4");
    applyStimulus(8'h5A, 1'b1, 0);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    txValid = 1'b0;
    bitQ.delete();
    rxQ.delete();
    frameLenQ.delete();
    inFrame = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("s5Cs", spiCs, 1);
    checkOutput("s5Sclk", spiSclk, 0);
    checkOutput("s5Mosi", spiMosi, 0);
    checkOutput("s5Busy", busy, 0);
    checkOutput("s5RxValid", rxValid, 0);
    checkOutput("s5Ready", txReady, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    resetStats();
    applyStimulus(8'hC7, 1'b1, 0);
    waitIdle();
    checkOutput("s5AfterCsLow", lastCsLow, 34);
    checkOutput("s5AfterMosiBits", capture, 8'hC7);
    checkOutput("s5AfterRxCount", rxCount, RX_PER_BYTE);

    $display("[TB] MISO held high");
    resetStats();
    misoLoop = 1'b0;
    applyStimulus(8'h5A, 1'b1, 0);
    waitIdle();
    checkOutput("s6CsLow", lastCsLow, 34);
    checkOutput("s6MosiBits", capture, 8'h5A);
    checkOutput("s6RxCount", rxCount, RX_PER_BYTE);
    checkOutput("s6RxData", rxData, (RX_PER_BYTE != 0) ? 8'hFF : 8'h00);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
